// File: rtl/alu_pkg.sv
// ALU opcode/alu_op constants and shared types for the ALU family.
// No logic of its own; no latency.
// No backpressure.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;

    localparam logic [1:0] ALU_OP_MEM    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA
    } shift_mode_t;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/serial_shifter.sv
// Bit-serial shifter: shift register plus down-counter, one bit per cycle.
// Latency: amt cycles after load; done is high during the cycle of the last shift.
// No backpressure; runs to completion once loaded, reset aborts.
module serial_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [WIDTH-1:0]         din,
    input  logic [$clog2(WIDTH)-1:0] amt,
    input  shift_mode_t              mode_in,
    output logic [WIDTH-1:0]         q_nxt,
    output logic                     done
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    logic [WIDTH-1:0]   q;
    logic [SHAMT_W-1:0] cnt;
    shift_mode_t        mode;

    always_comb begin
        q_nxt = q;
        case (mode)
            SH_SLL:  q_nxt = {q[WIDTH-2:0], 1'b0};
            SH_SRL:  q_nxt = {1'b0, q[WIDTH-1:1]};
            default: q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
        endcase
    end

    assign done = (cnt == CNT_ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= '0;
            cnt  <= '0;
            mode <= SH_SLL;
        end else if (load) begin
            q    <= din;
            cnt  <= amt;
            mode <= mode_in;
        end else if (cnt != '0) begin
            q   <= q_nxt;
            cnt <= cnt - CNT_ONE;
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Multi-cycle ALU: single-cycle logic/arith, bit-serial shifts.
// Latency: 1 cycle non-shift/illegal, 1+shamt cycles for shifts.
// in_ready only in IDLE; result held in DONE until out_ready.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  alu_res, sh_nxt, result_r;
    logic              zero_r, illegal_r;
    logic              accept, shift_go, sh_done;
    logic [SHAMT_W-1:0] shamt;
    shift_mode_t       mode;

    assign shamt    = op_b[SHAMT_W-1:0];
    assign accept   = (state == ST_IDLE) && in_valid;
    assign shift_go = accept && is_shift(alu_ctrl) && (shamt != '0);

    // Shift codes land here only with shamt == 0, where the result is op_a.
    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_ADD: alu_res = op_a + op_b;
            ALU_XOR: alu_res = op_a ^ op_b;
            ALU_SUB: alu_res = op_a + ~op_b + WIDTH'(1);
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        mode = SH_SRA;
        case (alu_ctrl)
            ALU_SLL: mode = SH_SLL;
            ALU_SRL: mode = SH_SRL;
            default: mode = SH_SRA;
        endcase
    end

    serial_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .load    (shift_go),
        .din     (op_a),
        .amt     (shamt),
        .mode_in (mode),
        .q_nxt   (sh_nxt),
        .done    (sh_done)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = shift_go ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                if (sh_done) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_r  <= '0;
            zero_r    <= 1'b1;
            illegal_r <= 1'b0;
        end else if (accept && !shift_go) begin
            result_r  <= alu_res;
            zero_r    <= (alu_res == '0);
            illegal_r <= alu_ctrl[3];
        end else if ((state == ST_SHIFT) && sh_done) begin
            result_r  <= sh_nxt;
            zero_r    <= (sh_nxt == '0);
            illegal_r <= 1'b0;
        end
    end

    assign result  = result_r;
    assign zero    = zero_r;
    assign illegal = illegal_r;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Randomized and directed bench for alu_seq_exec against a behavioural model.
module tb_alu_seq_exec;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a, op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    int checks = 0;
    int errors = 0;

    alu_seq_exec #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (c)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a ^ b;
            4'd4: return a << sh;
            4'd5: return a >> sh;
            4'd6: return a - b;
            4'd7: return 32'($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        if ((c == 4'd4 || c == 4'd5 || c == 4'd7) && sh != 0) return 1 + sh;
        return 1;
    endfunction

    // Drives one request and observes the response; judging is left to the callers.
    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input int stall,
                         output int lat, output logic [31:0] res, output logic zr, output logic il,
                         output bit hold_ok, output bit busy_ok, output bit retire_ok);
        int guard;
        hold_ok = 1; busy_ok = 1; retire_ok = 1; guard = 0;
        while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1; out_ready = (stall == 0);
        @(posedge clk); #1;
        // keep in_valid high with junk operands while busy; it must be ignored
        alu_ctrl = 4'($urandom); op_a = $urandom; op_b = $urandom;
        lat = 1;
        while (!out_valid && lat <= WIDTH + 4) begin
            if (in_ready) busy_ok = 0;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        res = result; zr = zero; il = illegal;
        if (!out_valid) begin
            lat = -1;
        end else begin
            if (in_ready) busy_ok = 0;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                if (!out_valid || result !== res || zero !== zr || illegal !== il || in_ready) hold_ok = 0;
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            if (out_valid || !in_ready) retire_ok = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; alu_ctrl = '0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", zero); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", illegal); end
    endtask

    task automatic test_add();
        int lat; logic [31:0] r; logic z, il; bit h, b, rt;
        do_op(ALU_ADD, 32'd5, 32'd7, 0, lat, r, z, il, h, b, rt);
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d exp 1", lat); end
        checks++; if (r !== 32'd12) begin errors++; $display("FAIL add_result got %h exp c", r); end
        checks++; if (z !== 1'b0 || il !== 1'b0) begin errors++; $display("FAIL add_flags got z=%b il=%b exp 0 0", z, il); end
        checks++; if (!b || !rt) begin errors++; $display("FAIL add_in_ready busy=%0d retire=%0d exp 1 1", b, rt); end
    endtask

    task automatic test_sub();
        int lat; logic [31:0] r; logic z, il; bit h, b, rt;
        do_op(ALU_SUB, 32'd9, 32'd9, 0, lat, r, z, il, h, b, rt);
        checks++; if (r !== 32'd0 || z !== 1'b1) begin errors++; $display("FAIL sub_zero got %h z=%b exp 0 z=1", r, z); end
        do_op(ALU_SUB, 32'd0, 32'd1, 0, lat, r, z, il, h, b, rt);
        checks++; if (r !== 32'hFFFF_FFFF || z !== 1'b0) begin errors++; $display("FAIL sub_wrap got %h z=%b exp ffffffff z=0", r, z); end
    endtask

    task automatic test_shift();
        int lat; logic [31:0] r; logic z, il; bit h, b, rt;
        do_op(ALU_SRA, 32'h8000_0010, 32'd4, 0, lat, r, z, il, h, b, rt);
        checks++; if (lat !== 5) begin errors++; $display("FAIL sra_latency got %0d exp 5", lat); end
        checks++; if (r !== 32'hF800_0001) begin errors++; $display("FAIL sra_result got %h exp f8000001", r); end
        checks++; if (!b) begin errors++; $display("FAIL sra_busy in_ready seen high while busy"); end
        do_op(ALU_SLL, 32'd1, 32'hFFFF_FFE0, 0, lat, r, z, il, h, b, rt);
        checks++; if (lat !== 1 || r !== 32'd1) begin errors++; $display("FAIL sll_shamt0 got lat=%0d res=%h exp lat=1 res=1", lat, r); end
        do_op(ALU_SRL, 32'h8000_0000, 32'd31, 0, lat, r, z, il, h, b, rt);
        checks++; if (lat !== 32 || r !== 32'd1) begin errors++; $display("FAIL srl_31 got lat=%0d res=%h exp lat=32 res=1", lat, r); end
    endtask

    task automatic test_illegal_backpressure();
        int lat; logic [31:0] r; logic z, il; bit h, b, rt;
        do_op(4'b1111, $urandom, $urandom, 0, lat, r, z, il, h, b, rt);
        checks++; if (il !== 1'b1 || r !== 32'd0 || z !== 1'b1 || lat !== 1)
            begin errors++; $display("FAIL illegal got il=%b res=%h z=%b lat=%0d exp 1 0 1 1", il, r, z, lat); end
        do_op(ALU_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 5, lat, r, z, il, h, b, rt);
        checks++; if (r !== 32'h0F0F_F0F0 || il !== 1'b0) begin errors++; $display("FAIL xor_result got %h il=%b exp 0f0ff0f0 0", r, il); end
        checks++; if (!h) begin errors++; $display("FAIL xor_hold outputs changed under out_ready=0"); end
        checks++; if (!b || !rt) begin errors++; $display("FAIL xor_handshake busy=%0d retire=%0d exp 1 1", b, rt); end
    endtask

    task automatic test_reset_mid_shift();
        int lat; int seen; logic [31:0] r; logic z, il; bit h, b, rt;
        alu_ctrl = ALU_SLL; op_a = 32'd3; op_b = 32'd10; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midreset_busy got in_ready=%b exp 0", in_ready); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1 || illegal !== 1'b0)
            begin errors++; $display("FAIL midreset_idle got rdy=%b vld=%b res=%h z=%b il=%b exp 1 0 0 1 0",
                                     in_ready, out_valid, result, zero, illegal); end
        seen = 0;
        repeat (15) begin @(posedge clk); #1; if (out_valid) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_output got %0d pulses exp 0", seen); end
        do_op(ALU_ADD, 32'd1, 32'd1, 0, lat, r, z, il, h, b, rt);
        checks++; if (r !== 32'd2 || lat !== 1) begin errors++; $display("FAIL midreset_add got %h lat=%0d exp 2 lat=1", r, lat); end
    endtask

    task automatic test_random();
        int lat, elat; logic [31:0] r, a, bb, er; logic [3:0] c; logic z, il; bit h, b, rt;
        int stall;
        for (int n = 0; n < 60; n++) begin
            c = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            a = $urandom; bb = $urandom;
            if (n % 5 == 0) bb = bb & 32'hFFFF_FFE0;
            stall = $urandom_range(0, 2);
            er = model_res(c, a, bb);
            elat = model_lat(c, bb);
            do_op(c, a, bb, stall, lat, r, z, il, h, b, rt);
            checks++; if (r !== er) begin errors++; $display("FAIL rnd_result op=%h a=%h b=%h got %h exp %h", c, a, bb, r, er); end
            checks++; if (z !== (er == 32'd0) || il !== c[3]) begin errors++; $display("FAIL rnd_flags op=%h got z=%b il=%b exp z=%b il=%b", c, z, il, er == 32'd0, c[3]); end
            checks++; if (lat !== elat) begin errors++; $display("FAIL rnd_latency op=%h got %0d exp %0d", c, lat, elat); end
            checks++; if (!h || !b || !rt) begin errors++; $display("FAIL rnd_handshake op=%h hold=%0d busy=%0d retire=%0d exp 1 1 1", c, h, b, rt); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_shift();
        test_illegal_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Multi-cycle ALU execute unit; the consumer of the 4-bit alu_ctrl code produced by alu_control.
- Accepts operands plus alu_ctrl over a valid/ready handshake and computes the result.
- Logic and arithmetic ops complete in 1 cycle; shifts run on a bit-serial shifter, 1 bit per cycle.
- Result is returned over a second valid/ready handshake. Intended for the area-reduced core variant, where it replaces the combinational ALU.

Parameters:
- WIDTH, 32, datapath width in bits; must be a power of two ≥ 8.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  unit can accept an operation.
- alu_ctrl  in  4  operation code (encodings in alu_pkg).
- op_a  in  WIDTH  first operand / shift source.
- op_b  in  WIDTH  second operand; bits [SHAMT_W-1:0] are the shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- illegal  out  1  alu_ctrl was not a defined code; qualified by out_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, illegal=0. Reset asserted mid-operation aborts the shift or pending result on that edge; nothing is emitted.
- Encodings: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111. All other codes are illegal.
- States:
  - IDLE: in_ready=1. On in_valid, latch operands and code.
    - Non-shift op → DONE.
    - Shift with shamt=0 → DONE; result=op_a.
    - Shift with shamt>0 → SHIFT; load the shift register with op_a and the counter with shamt.
  - SHIFT: in_ready=0. Each cycle, shift by 1:
    - SLL: shift left, fill 0.
    - SRL: shift right, fill 0.
    - SRA: shift right, fill the current MSB.
    - Decrement the counter. When it reaches 1, the last shift occurs and the state goes to DONE.
  - DONE: out_valid=1. result, zero and illegal are stable until the handshake. When out_ready=1, go to IDLE; out_valid drops the next cycle.
- in_ready is asserted in IDLE only. A new request cannot be accepted in the same cycle a result retires; throughput is at most 1 op per 2 cycles.
- Latency from accept edge to out_valid: non-shift = 1 cycle; shift = 1 + shamt cycles (max WIDTH).
- Arithmetic:
  - ADD/SUB are modulo 2^WIDTH; no carry or overflow outputs.
  - SUB is op_a + ~op_b + 1.
  - Only the low SHAMT_W bits of op_b are used for shifts; upper bits are ignored.
- Illegal code: result=0, zero=1, illegal=1, latency 1.
- Holding in_valid high while in_ready=0 has no effect; inputs are sampled only on the accept edge.
- Back-pressure: out_ready=0 holds DONE indefinitely with outputs stable.

Decomposition:
- alu_pkg (shared with alu_control and the combinational ALU):
  - ALU_AND…ALU_SRA localparams for the 4-bit codes.
  - ALU_OP_MEM/BRANCH/RTYPE 2-bit alu_op constants.
  - is_shift() function.
- Sub-module: serial_shifter. Holds the shift register and down-counter; has load/start, mode (SLL/SRL/SRA) and done interface. The top level holds the FSM, the single-cycle logic/arith path and the output registers.

Test Plan:
- Reset, then ADD a=5, b=7 with out_ready=1 → out_valid one cycle after accept; result=12, zero=0, illegal=0; in_ready low only while not IDLE.
- SUB a=9, b=9 → result=0, zero=1. SUB a=0, b=1 → result=32'hFFFFFFFF.
- SRA a=32'h80000010, b=4 → out_valid exactly 5 cycles after accept; result=32'hF8000001.
- SLL a=1, b=32'hFFFFFFE0 (shamt=0) → latency 1, result=1. SRL a=32'h80000000, b=31 → latency 32, result=1.
- alu_ctrl=1111 → illegal=1, result=0. Then XOR a=32'hF0F0F0F0, b=32'hFFFF0000 with out_ready=0 for 5 cycles → out_valid and result=32'h0F0FF0F0 held stable; retires on out_ready; in_ready=0 throughout.
- SLL a=3, b=10 with reset pulsed on the 4th SHIFT cycle → the next cycle shows IDLE values, with no out_valid pulse. A following ADD a=1, b=1 returns result=2.
